// File: rtl/rc4_ksa_if.sv
// Control and S-box RAM port bundle for the RC4 key-scheduling controller.
interface rc4_ksa_if;
  logic        start;
  logic [23:0] key;
  logic        busy;
  logic        done;
  logic [31:0] mem_d;
  logic [7:0]  mem_wa;
  logic [7:0]  mem_ra;
  logic        mem_we;
  logic [31:0] mem_q;

  modport master (
    output start, key, mem_q,
    input  busy, done, mem_d, mem_wa, mem_ra, mem_we
  );

  modport slave (
    input  start, key, mem_q,
    output busy, done, mem_d, mem_wa, mem_ra, mem_we
  );
endinterface

// File: rtl/rc4_ksa.sv
// RC4 key schedule over an external 256x32 S-box RAM with registered read data.
// Optional macro RC4_KSA_KEY_LATCH_EN captures the key at start instead of using it live.
module rc4_ksa (
  input  logic       clk,
  input  logic       reset,
  rc4_ksa_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_RD_I, S_CALC_J, S_GET_J, S_WR_J, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  i, j, si, sj;
  logic [1:0]  kidx;
  logic [7:0]  keybyte, jn;
  logic [23:0] key_use;
  logic        busy, done, mem_we;
  logic [7:0]  mem_wa, mem_ra;
  logic [31:0] mem_d;
  logic        accept;

  assign accept = (state == S_IDLE) && bus.start;

`ifdef RC4_KSA_KEY_LATCH_EN
  logic [23:0] key_r;
  always_ff @(posedge clk) begin
    if (accept) key_r <= bus.key;
  end
  assign key_use = key_r;
`else
  assign key_use = bus.key;
`endif

  always_comb begin
    case (kidx)
      2'd0:    keybyte = key_use[23:16];
      2'd1:    keybyte = key_use[15:8];
      default: keybyte = key_use[7:0];
    endcase
  end

  // mem_q carries S[i] during CALC_J, so the new j is formed in the same cycle
  assign jn = j + bus.mem_q[7:0] + keybyte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_wa    = 8'd0;
    mem_ra    = 8'd0;
    mem_d     = 32'd0;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = S_INIT;
      end
      S_INIT: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        mem_wa = i;
        mem_d  = {24'd0, i};
        if (i == 8'hFF) state_nxt = S_RD_I;
      end
      S_RD_I: begin
        busy      = 1'b1;
        mem_ra    = i;
        state_nxt = S_CALC_J;
      end
      S_CALC_J: begin
        busy      = 1'b1;
        mem_ra    = jn;
        state_nxt = S_GET_J;
      end
      S_GET_J: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_wa    = i;
        mem_d     = {24'd0, bus.mem_q[7:0]};
        state_nxt = S_WR_J;
      end
      S_WR_J: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_wa    = j;
        mem_d     = {24'd0, si};
        state_nxt = (i == 8'hFF) ? S_DONE : S_RD_I;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i    <= 8'd0;
      j    <= 8'd0;
      kidx <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            i    <= 8'd0;
            j    <= 8'd0;
            kidx <= 2'd0;
          end
        end
        S_INIT:   i <= i + 8'd1;
        S_CALC_J: j <= jn;
        S_WR_J: begin
          kidx <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
          if (i != 8'hFF) i <= i + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_CALC_J) si <= bus.mem_q[7:0];
    if (state == S_GET_J)  sj <= bus.mem_q[7:0];
  end

  // sj is held for observation only; the GET_J write already uses mem_q directly
  logic unused_bits;
  assign unused_bits = ^{bus.mem_q[31:8], sj};

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.mem_we = mem_we;
  assign bus.mem_wa = mem_wa;
  assign bus.mem_ra = mem_ra;
  assign bus.mem_d  = mem_d;

endmodule

// File: tb/tb_rc4_ksa.sv
// Scoreboard bench for rc4_ksa: RAM model, expectation queue and done/snapshot monitor.
module tb_rc4_ksa;

  localparam int K_SNAP = 0;
  localparam int K_DONE = 1;

  typedef struct {
    int            kind;
    int            at_cyc;
    logic [2047:0] sbox;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        accept;
  int          run_cyc;
  int          we_cnt;
  int          checks;
  int          errors;
  logic [31:0] ram [256];
  exp_t        exp_q [$];

  rc4_ksa_if bus ();

  rc4_ksa dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with registered read data
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_wa] <= bus.mem_d;
    bus.mem_q <= ram[bus.mem_ra];
  end

  // Cycle label: the period following the start-sampling edge is cycle 1
  always @(posedge clk) begin
    if (accept) begin
      run_cyc <= 1;
      we_cnt  <= 0;
    end else begin
      run_cyc <= run_cyc + 1;
      we_cnt  <= we_cnt + (bus.mem_we ? 1 : 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic int first_bad(input logic [2047:0] e);
    for (int k = 0; k < 256; k++)
      if (ram[k] !== {24'h0, e[k*8 +: 8]}) return k;
    return -1;
  endfunction

  task automatic chk_ram(input string name, input logic [2047:0] e);
    int idx;
    checks++;
    idx = first_bad(e);
    if (idx >= 0) begin
      errors++;
      $display("FAIL %s: S[%0d] got %h want %h", name, idx, ram[idx], {24'h0, e[idx*8 +: 8]});
    end
  endtask

  function automatic logic [2047:0] ident();
    logic [2047:0] s;
    for (int k = 0; k < 256; k++) s[k*8 +: 8] = k[7:0];
    return s;
  endfunction

  // Reference RC4 KSA; key kb replaces ka from iteration sw onward
  function automatic logic [2047:0] ksa_model(input logic [23:0] ka, input logic [23:0] kb,
                                              input int sw);
    logic [7:0]    s [256];
    logic [7:0]    jj, t, kbyte;
    logic [23:0]   k;
    logic [2047:0] r;
    for (int n = 0; n < 256; n++) s[n] = n[7:0];
    jj = 8'd0;
    for (int n = 0; n < 256; n++) begin
      k = (n >= sw) ? kb : ka;
      case (n % 3)
        0:       kbyte = k[23:16];
        1:       kbyte = k[15:8];
        default: kbyte = k[7:0];
      endcase
      jj = jj + s[n] + kbyte;
      t = s[n]; s[n] = s[jj]; s[jj] = t;
    end
    for (int n = 0; n < 256; n++) r[n*8 +: 8] = s[n];
    return r;
  endfunction

  // Monitor: snapshot compares at scheduled cycles and full compare on each done
  always @(negedge clk) begin
    if (exp_q.size() != 0 && exp_q[0].kind == K_SNAP && run_cyc == exp_q[0].at_cyc) begin
      chk_ram("snapshot", exp_q[0].sbox);
      void'(exp_q.pop_front());
    end
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0 || exp_q[0].kind != K_DONE) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d want none", run_cyc);
      end else begin
        chk("done_cycle", run_cyc, 32'd1281);
        chk("we_count", we_cnt, 32'd768);
        chk("busy_in_done", {31'd0, bus.busy}, 32'd0);
        chk_ram("sbox_final", exp_q[0].sbox);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic start_run(input logic [23:0] k);
    bus.key   = k;
    bus.start = 1'b1;
    accept    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    accept    = 1'b0;
  endtask

  task automatic push_exp(input int kind, input int at, input logic [2047:0] s);
    exp_t e;
    e.kind   = kind;
    e.at_cyc = at;
    e.sbox   = s;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int n);
    for (int c = 0; c < 3000; c++) begin
      if (run_cyc == n) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL wait_cycle: got %0d want %0d", run_cyc, n);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 3000 && exp_q.size() != 0; c++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [2047:0] snap2;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    accept    = 1'b0;
    bus.start = 1'b0;
    bus.key   = 24'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_wa", {24'd0, bus.mem_wa}, 32'd0);
    chk("rst_ra", {24'd0, bus.mem_ra}, 32'd0);
    chk("rst_d", bus.mem_d, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Key 0: identity after INIT, first swap after iteration 2, then full result
    snap2 = ident();
    snap2[2*8 +: 8] = 8'd3;
    snap2[3*8 +: 8] = 8'd2;
    start_run(24'h000000);
    push_exp(K_SNAP, 257, ident());
    push_exp(K_SNAP, 269, snap2);
    push_exp(K_DONE, 0, ksa_model(24'h000000, 24'h000000, 256));
    wait_drain();

    // Stray start pulses mid-run must be ignored
    start_run(24'h1A2B3C);
    push_exp(K_DONE, 0, ksa_model(24'h1A2B3C, 24'h1A2B3C, 256));
    wait_until(10);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_until(700);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();

    // Abort with reset at cycle 600, then a clean rerun
    start_run(24'h1A2B3C);
    wait_until(600);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_we", {31'd0, bus.mem_we}, 32'd0);
    chk("abort_d", bus.mem_d, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_run(24'h1A2B3C);
    push_exp(K_DONE, 0, ksa_model(24'h1A2B3C, 24'h1A2B3C, 256));
    wait_drain();

    // Key change during cycle 300; first CALC_J to see it is iteration 11
    start_run(24'h1A2B3C);
`ifdef RC4_KSA_KEY_LATCH_EN
    push_exp(K_DONE, 0, ksa_model(24'h1A2B3C, 24'h1A2B3C, 256));
`else
    push_exp(K_DONE, 0, ksa_model(24'h1A2B3C, 24'h5A0F77, 11));
`endif
    wait_until(300);
    bus.key = 24'h5A0F77;
    wait_drain();
    bus.key = 24'h0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
